fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDRESS_WIDTH SHALL default to 32 and set the width of all address/PC/immediate ports.
REQ-002 Parameter RESET_PC SHALL default to 0 and set the PC value loaded on reset.
REQ-003 Parameter HALT_INSTR SHALL default to 32'h0000006F (self-loop jump) and mark the halt instruction.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; sampled only in IDLE and at issue handoff.
- mem_req  out  1  instruction-memory request.
- mem_addr  out  ADDRESS_WIDTH  fetch address.
- mem_ack  in  1  memory returns mem_rdata this cycle.
- mem_rdata  in  32  fetched word.
- instr  out  32  registered instruction to decode.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  decode accepts instr.
- PCsrc  in  1  branch taken for the instruction being accepted.
- ImmOp  in  ADDRESS_WIDTH  branch offset for the instruction being accepted.
- PC  out  ADDRESS_WIDTH  address of the current/next fetch.
- halted  out  1  sequencer has stopped on HALT_INSTR.
- retire_count  out  32  accepted non-halt instructions.

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, REQ, ISSUE, HALT.
REQ-006 IDLE: mem_req=0, instr_valid=0; go to REQ on the next edge when en=1, else remain.
REQ-007 REQ: mem_req=1, mem_addr=PC; PC and mem_addr SHALL stay stable until mem_ack=1.
REQ-008 REQ with mem_ack=1: capture mem_rdata into instr and go to ISSUE on the same edge; en is ignored in REQ.
REQ-009 mem_ack in any state other than REQ SHALL be ignored.
REQ-010 ISSUE: instr_valid=1, mem_req=0; instr SHALL stay stable until instr_valid&&instr_ready.
REQ-011 Handshake in ISSUE with instr==HALT_INSTR: go to HALT; PC and retire_count unchanged; PCsrc/ImmOp ignored.
REQ-012 Handshake in ISSUE with any other instr: PC <= PCsrc ? PC+ImmOp : PC+4, bits [1:0] forced to 0; retire_count += 1; next state REQ if en=1, else IDLE.
REQ-013 PC arithmetic SHALL be modulo 2^ADDRESS_WIDTH (wrap, no flag); ImmOp is treated as two's-complement.
REQ-014 retire_count SHALL wrap from 32'hFFFFFFFF to 0.
REQ-015 HALT: halted=1, mem_req=0, instr_valid=0; remain until reset regardless of en.
REQ-016 Best-case latency: en=1 in cycle 0 -> mem_req cycle 1; mem_ack in cycle 1 -> instr_valid cycle 2; peak throughput one instruction per 2 cycles.
REQ-017 PCsrc and ImmOp SHALL be sampled only on the accepting edge of the ISSUE handshake.

Reset
REQ-018 rst=1 SHALL asynchronously force state=IDLE, PC=RESET_PC, instr=0, retire_count=0, and mem_req, instr_valid and halted to 0, including mid-REQ or mid-ISSUE.
REQ-019 After rst deasserts, the first fetch SHALL be to RESET_PC; a mem_ack arriving for a request aborted by reset SHALL be ignored.

Verification
REQ-020 Sequential: en=1, zero-wait ack, instr_ready=1, PCsrc=0 -> mem_addr 0,4,8 on cycles 1,3,5; retire_count=3 after the third handshake.
REQ-021 Branch: PC=0x10, PCsrc=1, ImmOp=0xFFFFFFF8 at handshake -> next mem_addr=0x08; ImmOp=0x6 -> next mem_addr=0x14 (low bits cleared).
REQ-022 Backpressure: mem_ack delayed 3 cycles, then instr_ready held 0 for 4 cycles -> mem_addr/mem_req stable for 4 cycles, then instr stable with instr_valid=1 for 5 cycles; a single PC advance.
REQ-023 Halt: fetch returns 32'h0000006F, accepted -> halted=1 next cycle, PC unchanged, no further mem_req with en=1.
REQ-024 Reset mid-REQ: rst pulsed while mem_req=1 at PC=0x40, then mem_ack=1 one cycle after release -> ack ignored; state IDLE, PC=RESET_PC, all outputs 0.
REQ-025 Wrap and en drop: PC=0xFFFFFFFC, PCsrc=0, en=0 at handshake -> PC=0, state IDLE, mem_req stays 0 until en=1.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: run control, instruction-memory port, decode handoff and status.
interface fetch_sequencer_if #(
    parameter int unsigned ADDRESS_WIDTH = 32
);
    localparam int unsigned DATA_WIDTH = 32;

    logic                     en;
    logic                     mem_req;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic                     mem_ack;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    logic [DATA_WIDTH-1:0]    instr;
    logic                     instr_valid;
    logic                     instr_ready;
    logic                     PCsrc;
    logic [ADDRESS_WIDTH-1:0] ImmOp;
    logic [ADDRESS_WIDTH-1:0] PC;
    logic                     halted;
    logic [DATA_WIDTH-1:0]    retire_count;

    // Sequencer side.
    modport master (
        input  en, mem_ack, mem_rdata, instr_ready, PCsrc, ImmOp,
        output mem_req, mem_addr, instr, instr_valid, PC, halted, retire_count
    );

    // Memory/decode/environment side.
    modport slave (
        output en, mem_ack, mem_rdata, instr_ready, PCsrc, ImmOp,
        input  mem_req, mem_addr, instr, instr_valid, PC, halted, retire_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests a word at PC, hands it to decode, then
// advances PC sequentially or by the branch offset supplied at acceptance.
module fetch_sequencer #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
    parameter logic [31:0]              HALT_INSTR    = 32'h0000_006F
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus
);
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t                   state_q;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] pc_d;
    logic [ADDRESS_WIDTH-1:0] pc_sum;
    logic [DATA_WIDTH-1:0]    instr_q;
    logic [DATA_WIDTH-1:0]    retire_q;
    logic                     mem_req_q;
    logic                     instr_valid_q;
    logic                     halted_q;
    logic                     accept;

    // Next PC for an accepted non-halt instruction, kept word aligned; wraps naturally.
    always_comb begin
        pc_sum = bus.PCsrc ? (pc_q + bus.ImmOp) : (pc_q + ADDRESS_WIDTH'(4));
        pc_d   = {pc_sum[ADDRESS_WIDTH-1:2], 2'b00};
    end

    assign accept = instr_valid_q && bus.instr_ready;

    // Sequencer FSM with all outputs held in registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            retire_q      <= '0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.en) begin
                        state_q   <= REQ;
                        mem_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        instr_q       <= bus.mem_rdata;
                        state_q       <= ISSUE;
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        instr_valid_q <= 1'b0;
                        if (instr_q == HALT_INSTR) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            pc_q     <= pc_d;
                            retire_q <= retire_q + DATA_WIDTH'(1);
                            if (bus.en) begin
                                state_q   <= REQ;
                                mem_req_q <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = pc_q;
    assign bus.instr        = instr_q;
    assign bus.instr_valid  = instr_valid_q;
    assign bus.PC           = pc_q;
    assign bus.halted       = halted_q;
    assign bus.retire_count = retire_q;
endmodule
